// File: rtl/output_conditioner_if.sv
// Core-side bundle of the output conditioner: steady level and pulse requests
// in, conditioned pin plus busy and edge strobes out.
interface output_conditioner_if;
  logic level;
  logic pulse;
  logic pin;
  logic busy;
  logic positiveedge;
  logic negativeedge;

  modport master (
    output level,
    output pulse,
    input  pin,
    input  busy,
    input  positiveedge,
    input  negativeedge
  );

  modport slave (
    input  level,
    input  pulse,
    output pin,
    output busy,
    output positiveedge,
    output negativeedge
  );
endinterface

// File: rtl/output_conditioner.sv
// Drives one output line with a guaranteed minimum dwell between edges, from a
// steady level request plus one-shot pulses. OUTCOND_SYNC_INPUTS_EN adds input synchronizers.
module output_conditioner #(
  parameter int unsigned COUNTER_WIDTH = 5,
  parameter int unsigned MIN_DWELL     = 10,
  parameter int unsigned PULSE_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  output_conditioner_if.slave  oc
);

  typedef enum logic {
    ST_LEVEL = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

  // Requests shorter than the dwell (including 0) are stretched to the dwell.
  localparam int unsigned EFF_PULSE = (PULSE_WIDTH < MIN_DWELL) ? MIN_DWELL : PULSE_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] DWELL_MAX  = COUNTER_WIDTH'(MIN_DWELL);
  localparam logic [COUNTER_WIDTH-1:0] PULSE_LAST = COUNTER_WIDTH'(EFF_PULSE - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);

  logic level_in;
  logic pulse_in;

`ifdef OUTCOND_SYNC_INPUTS_EN
  logic [1:0] level_sync_q, level_sync_d;
  logic [1:0] pulse_sync_q, pulse_sync_d;

  always_comb begin
    level_sync_d = {level_sync_q[0], oc.level};
    pulse_sync_d = {pulse_sync_q[0], oc.pulse};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_sync_q <= '0;
      pulse_sync_q <= '0;
    end else begin
      level_sync_q <= level_sync_d;
      pulse_sync_q <= pulse_sync_d;
    end
  end

  assign level_in = level_sync_q[1];
  assign pulse_in = pulse_sync_q[1];
`else
  assign level_in = oc.level;
  assign pulse_in = oc.pulse;
`endif

  state_e                    state_q, state_d;
  logic                      pin_q, pin_d;
  logic                      pending_q, pending_d;
  logic                      pos_q, pos_d;
  logic                      neg_q, neg_d;
  logic [COUNTER_WIDTH-1:0]  dwell_q, dwell_d;
  logic [COUNTER_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic [COUNTER_WIDTH-1:0]  dwell_inc;
  logic                      ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    pin_d     = pin_q;
    pending_d = pending_q;
    pcnt_d    = pcnt_q;

    // Ready once the current cycle completes MIN_DWELL cycles at this value.
    dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + CNT_ONE;
    ready     = (dwell_inc == DWELL_MAX);

    case (state_q)
      ST_LEVEL: begin
        if (pulse_in) begin
          pending_d = 1'b1;
        end
        if (ready && (pending_q || pulse_in)) begin
          pin_d     = ~pin_q;
          pending_d = 1'b0;
          pcnt_d    = '0;
          state_d   = ST_PULSE;
        end else if (ready && (level_in != pin_q)) begin
          pin_d = level_in;
        end
      end
      ST_PULSE: begin
        if (pcnt_q == PULSE_LAST) begin
          pin_d   = ~pin_q;
          state_d = ST_LEVEL;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LEVEL;
      end
    endcase

    dwell_d = (pin_d != pin_q) ? '0 : dwell_inc;
    pos_d   = pin_d & ~pin_q;
    neg_d   = ~pin_d & pin_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LEVEL;
      pin_q     <= 1'b0;
      pending_q <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      dwell_q   <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      dwell_q   <= dwell_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign oc.pin          = pin_q;
  assign oc.positiveedge = pos_q;
  assign oc.negativeedge = neg_q;
  assign oc.busy         = (state_q == ST_PULSE) | pending_q | (level_in != pin_q);

endmodule

// File: doc/output_conditioner.md
Name: output_conditioner

Overview:
- Transmit-side counterpart of the input conditioner; drives a single output line.
- Enforces a minimum dwell time between edges, so a far-end input conditioner with the same wait time never rejects a transition as noise.
- Accepts a steady requested level plus a one-shot pulse request; reports edges and busy status.
- Sits between core logic and an output pin / inter-board line.

Parameters:
counterwidth, 5, width of dwell and pulse counters
mindwell, 10, minimum clock cycles the pin must hold a value before it may change again (1..2^counterwidth-1)
pulsewidth, 12, cycles the pin is held inverted for a pulse request; values below mindwell are raised to mindwell; 0 means mindwell

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
level  input  1  requested steady line level
pulse  input  1  one-cycle strobe requesting a single inverted pulse on the line
pin  output  1  conditioned output line, registered
busy  output  1  high while a requested change or pulse is not yet complete
positiveedge  output  1  one-cycle strobe, high in the cycle pin first reads 1
negativeedge  output  1  one-cycle strobe, high in the cycle pin first reads 0

Behaviour:
- Reset, sampled on posedge while high:
  - pin=0, busy=0, positiveedge=0, negativeedge=0.
  - dwell counter=0, pulse counter=0, pulse_pending=0, state=LEVEL.
  - Takes effect at the next edge even mid-pulse; the pin returns to 0 with no edge strobe.
- Dwell counter:
  - Clears on every pin change.
  - Otherwise increments each cycle and saturates at mindwell.
  - "Ready" means dwell==mindwell.
  - After reset release, the first change is allowed once mindwell cycles have elapsed.
- State LEVEL:
  - A pulse strobe sets pulse_pending. Further strobes while pending merge into one pulse.
  - If ready and pulse_pending: pin<=~pin, clear pulse_pending, pulse counter<=0, go to PULSE.
  - Else if ready and level!=pin: pin<=level.
  - Else hold.
  - Latency when ready: pin changes at the same posedge that samples the request (1 registered cycle).
- State PULSE:
  - Pulse counter increments each cycle.
  - When it reaches effective width minus 1, pin<=~pin (restoring the pre-pulse value) and go to LEVEL.
  - Result: pin stays inverted for exactly max(pulsewidth, mindwell) cycles.
  - level is ignored. Pulse strobes arriving here are dropped, not queued.
- Simultaneous pulse request and level change while ready: the pulse wins. The level change is applied once the dwell after the pulse return is satisfied.
- Edge strobes:
  - Registered alongside pin.
  - positiveedge=1 for exactly the cycle following a 0->1 pin update; negativeedge likewise for 1->0.
  - Never both high. Both 0 otherwise.
- busy: combinational OR of (state==PULSE), pulse_pending, and (level!=pin).
- Width rules:
  - Counters are counterwidth bits and never wrap; they saturate or reset as above.
  - Effective pulse width is computed at elaboration.

Optional Feature:
- Macro: OUTCOND_SYNC_INPUTS_EN.
- Defined:
  - level and pulse each pass through a two-flop synchronizer (reset to 0) before use.
  - Adds 2 cycles of latency.
  - Allows asynchronous sources.
- Undefined:
  - Inputs are used directly and must be synchronous to clk.
  - Latency is as stated above.

Test Plan:
- Reset for 2 cycles, then hold level=1 from reset release -> pin rises at the 10th posedge after release; positiveedge high 1 cycle; busy high until that edge.
- Pin=0 and ready, pulse strobe at edge n -> pin=1 for edges n..n+11; 0 from n+12; positiveedge at n, negativeedge at n+12; level=1 raised at n+2 lifts pin no earlier than edge n+22.
- level toggles every 2 cycles for 60 cycles -> pin changes at most once per 10 cycles; each pin value lasts ≥10 cycles; edge strobes match pin changes one-for-one.
- Pulse and level change in the same ready cycle, pin=0, level=1 -> pulse 12 cycles high, return to 0, pin goes 1 ten cycles later.
- Assert reset at cycle 5 of a pulse -> pin=0 next edge, no negativeedge, busy=0, no pending pulse replayed.
- With OUTCOND_SYNC_INPUTS_EN and ready: level change -> pin changes 3 posedges after level is applied, vs 1 without the macro.
